cm_dly_pipe: RTL and testbench

Multi-channel, valid-tracked delay line with a delay selectable at run time from 0 to MAX_LEN cycles, a global advance enable (stall) and a synchronous flush. It is the general-purpose successor of the fixed-length data shift register in lib_cm. It aligns side-band or parallel-lane data against pipelines whose latency is configured at run time. Delay changes are made safe: in-flight items drain before the new delay is applied.

---
 rtl/cm_pkg.sv | 23 ++
 rtl/cm_dly_stage.sv | 54 +++++
 rtl/cm_dly_pipe.sv | 192 +++++++++++++++++++
 tb/tb_cm_dly_pipe.sv | 232 +++++++++++++++++++++++
 4 files changed

// File: rtl/cm_pkg.sv
// Purpose: shared types and helpers for the common-library pipeline blocks.
// Latency: n/a (declarations only).
// Backpressure: n/a.
package cm_pkg;

  // Data-stage reset policy: only the head stage, or every stage.
  typedef enum logic {
    SHR_RST_FIRST,
    SHR_RST_ALL
  } t_shr_rst;

  // Delay-pipe control states.
  typedef enum logic {
    S_RUN,
    S_DRAIN
  } t_dly_pipe_st;

  // Width needed to encode a delay from 0 up to max_len.
  function automatic int dly_w(input int max_len);
    return $clog2(max_len + 1);
  endfunction

endpackage

// File: rtl/cm_dly_stage.sv
// Purpose: one delay-line register stage (CH lanes of data plus a valid bit).
// Latency: 1 cycle when enabled; holds its contents while i_en=0.
// Backpressure: none; flush clears valid regardless of i_en, data is never cleared by flush.
module cm_dly_stage
  import cm_pkg::*;
#(
  parameter int       CH       = 2,
  parameter type      DTYPE    = logic [7:0],
  parameter t_shr_rst RST_MODE = SHR_RST_FIRST,
  parameter bit       FIRST    = 1'b0
) (
  input  logic            i_clk,
  input  logic            i_rst_n,
  input  logic            i_en,
  input  logic            i_flush,
  input  logic            i_vld,
  input  DTYPE [CH-1:0]   i_data,
  output logic            o_vld,
  output DTYPE [CH-1:0]   o_data
);

  // Valid bit: always reset, cleared by flush, otherwise advances with i_en.
  always_ff @(posedge i_clk or negedge i_rst_n) begin
    if (!i_rst_n) begin
      o_vld <= 1'b0;
    end else if (i_flush) begin
      o_vld <= 1'b0;
    end else if (i_en) begin
      o_vld <= i_vld;
    end
  end

  // Data: only stages selected by the reset policy carry a reset.
  generate
    if (FIRST || (RST_MODE == SHR_RST_ALL)) begin : g_rst
      // Resettable data register.
      always_ff @(posedge i_clk or negedge i_rst_n) begin
        if (!i_rst_n) begin
          o_data <= '0;
        end else if (i_en) begin
          o_data <= i_data;
        end
      end
    end else begin : g_norst
      // Plain data register; contents are qualified by the valid bit.
      always_ff @(posedge i_clk) begin
        if (i_en) begin
          o_data <= i_data;
        end
      end
    end
  endgenerate

endmodule

// File: rtl/cm_dly_pipe.sv
// Purpose: multi-channel valid-tracked delay line, run-time delay 0..MAX_LEN; optional occupancy counter via CM_DLY_PIPE_CNT_EN.
// Latency: q_dly cycles (0 = combinational bypass); each i_en=0 cycle adds one.
// Backpressure: o_rdy drops while a delay change is pending; in-flight items drain before the new delay is applied.
module cm_dly_pipe
  import cm_pkg::*;
#(
  parameter int       MAX_LEN  = 8,
  parameter int       CH       = 2,
  parameter type      DTYPE    = logic [7:0],
  parameter t_shr_rst RST_MODE = SHR_RST_FIRST,
  parameter int       RST_DLY  = MAX_LEN,
  parameter int       DW       = dly_w(MAX_LEN)
) (
  input  logic            i_clk,
  input  logic            i_rst_n,
  input  logic            i_en,
  input  logic            i_flush,
  input  logic [DW-1:0]   i_dly,
  input  logic            i_vld,
  output logic            o_rdy,
  input  DTYPE [CH-1:0]   i_data,
  output logic            o_vld,
  output DTYPE [CH-1:0]   o_data,
  output logic            o_busy,
  output logic            o_dly_err,
  output logic [DW-1:0]   o_cnt
);

  localparam logic [DW-1:0] MAX_D = DW'(MAX_LEN);
  localparam logic [DW-1:0] RST_D = DW'(RST_DLY);

  t_dly_pipe_st state, state_nxt;
  logic [DW-1:0] q_dly;
  logic [DW-1:0] req;
  logic          load;
  logic          busy;
  logic          tap_vld;
  DTYPE [CH-1:0] tap_data;

  logic [MAX_LEN-1:0] vld_in;
  logic [MAX_LEN-1:0] svld;
  DTYPE [CH-1:0]      sdin  [MAX_LEN];
  DTYPE [CH-1:0]      sdata [MAX_LEN];

  assign req = (i_dly > MAX_D) ? MAX_D : i_dly;

  // Stage chain. Valid is gated off beyond the active tap so stages past it
  // never hold stale items that could reappear after the delay grows.
  generate
    for (genvar k = 0; k < MAX_LEN; k++) begin : g_stage
      localparam logic [DW-1:0] K = DW'(k);
      if (k == 0) begin : g_head
        assign vld_in[k] = i_vld & o_rdy & (q_dly > K);
        assign sdin[k]   = i_data;
      end else begin : g_body
        assign vld_in[k] = svld[k-1] & (q_dly > K);
        assign sdin[k]   = sdata[k-1];
      end
      cm_dly_stage #(
        .CH       (CH),
        .DTYPE    (DTYPE),
        .RST_MODE (RST_MODE),
        .FIRST    (k == 0)
      ) u_stage (
        .i_clk   (i_clk),
        .i_rst_n (i_rst_n),
        .i_en    (i_en),
        .i_flush (i_flush),
        .i_vld   (vld_in[k]),
        .i_data  (sdin[k]),
        .o_vld   (svld[k]),
        .o_data  (sdata[k])
      );
    end
  endgenerate

  // Tap mux: select stage q_dly-1.
  always_comb begin
    tap_vld  = 1'b0;
    tap_data = '0;
    for (int i = 0; i < MAX_LEN; i++) begin
      if (q_dly == DW'(i + 1)) begin
        tap_vld  = svld[i];
        tap_data = sdata[i];
      end
    end
  end

  // Busy: any valid item in the active stages 0..q_dly-1.
  always_comb begin
    busy = 1'b0;
    for (int i = 0; i < MAX_LEN; i++) begin
      if ((DW'(i) < q_dly) && svld[i]) begin
        busy = 1'b1;
      end
    end
  end

  // Output select: delay 0 bypasses the stages entirely.
  always_comb begin
    if (q_dly == '0) begin
      o_vld  = i_vld & o_rdy;
      o_data = i_data;
    end else begin
      o_vld  = tap_vld;
      o_data = tap_data;
    end
  end

  assign o_busy = busy;

  // FSM state register.
  always_ff @(posedge i_clk or negedge i_rst_n) begin
    if (!i_rst_n) begin
      state <= S_RUN;
    end else begin
      state <= state_nxt;
    end
  end

  // FSM next state: a busy pipe must drain before a new delay is taken.
  always_comb begin
    state_nxt = state;
    case (state)
      S_RUN:   if ((req != q_dly) && busy) state_nxt = S_DRAIN;
      S_DRAIN: if (!busy) state_nxt = S_RUN;
      default: state_nxt = S_RUN;
    endcase
  end

  // FSM outputs: accept only when settled; load the request once empty.
  always_comb begin
    o_rdy = 1'b0;
    load  = 1'b0;
    case (state)
      S_RUN: begin
        o_rdy = (req == q_dly);
        load  = (req != q_dly) && !busy;
      end
      S_DRAIN: begin
        load = !busy;
      end
      default: ;
    endcase
  end

  // Applied delay register.
  always_ff @(posedge i_clk or negedge i_rst_n) begin
    if (!i_rst_n) begin
      q_dly <= RST_D;
    end else if (load) begin
      q_dly <= req;
    end
  end

  // Out-of-range request flag, sampled every cycle.
  always_ff @(posedge i_clk or negedge i_rst_n) begin
    if (!i_rst_n) begin
      o_dly_err <= 1'b0;
    end else begin
      o_dly_err <= (i_dly > MAX_D);
    end
  end

`ifdef CM_DLY_PIPE_CNT_EN
  logic [DW-1:0] cnt;
  logic          cnt_inc;
  logic          cnt_dec;

  // Bypass items never occupy a stage, so they are not counted.
  assign cnt_inc = i_vld & o_rdy & i_en & (q_dly != '0);
  assign cnt_dec = i_en & tap_vld & (q_dly != '0);

  // Occupancy counter over the active stages.
  always_ff @(posedge i_clk or negedge i_rst_n) begin
    if (!i_rst_n) begin
      cnt <= '0;
    end else if (i_flush) begin
      cnt <= '0;
    end else if (cnt_inc && !cnt_dec) begin
      cnt <= cnt + 1'b1;
    end else if (cnt_dec && !cnt_inc) begin
      cnt <= cnt - 1'b1;
    end
  end

  assign o_cnt = cnt;
`else
  assign o_cnt = '0;
`endif

endmodule

// File: tb/tb_cm_dly_pipe.sv
// Purpose: directed self-checking bench for cm_dly_pipe (MAX_LEN=8, CH=2, 8-bit lanes).
// Latency: n/a.
// Backpressure: n/a.
module tb_cm_dly_pipe;

  logic            clk;
  logic            rst_n;
  logic            en;
  logic            flush;
  logic [3:0]      dly;
  logic            vld;
  logic            rdy;
  logic [1:0][7:0] din;
  logic            ovld;
  logic [1:0][7:0] dout;
  logic            busy;
  logic            err;
  logic [3:0]      cnt;

  int checks = 0;
  int errors = 0;
  int cnt_exp;

  cm_dly_pipe #(
    .MAX_LEN (8),
    .CH      (2)
  ) dut (
    .i_clk     (clk),
    .i_rst_n   (rst_n),
    .i_en      (en),
    .i_flush   (flush),
    .i_dly     (dly),
    .i_vld     (vld),
    .o_rdy     (rdy),
    .i_data    (din),
    .o_vld     (ovld),
    .o_data    (dout),
    .o_busy    (busy),
    .o_dly_err (err),
    .o_cnt     (cnt)
  );

  initial clk = 1'b0;
  always #5 clk = ~clk;

  task automatic chk(input string tag, input logic [31:0] obs, input logic [31:0] exp);
    checks++;
    assert (obs === exp) else begin
      errors++;
      $error("FAIL %s observed=%0h expected=%0h", tag, obs, exp);
    end
  endtask

  task automatic tick;
    @(posedge clk);
    #2;
  endtask

  // Lane 0 carries the value, lane 1 its complement.
  function automatic logic [15:0] pk(input logic [7:0] v);
    return {~v, v};
  endfunction

  initial begin
    rst_n = 1'b0; en = 1'b1; flush = 1'b0; dly = 4'd8; vld = 1'b0; din = '0;
    #12;
    chk("rst_vld", 32'(ovld), 0);
    chk("rst_busy", 32'(busy), 0);
    chk("rst_err", 32'(err), 0);
    chk("rst_cnt", 32'(cnt), 0);
    chk("rst_rdy", 32'(rdy), 1);
    rst_n = 1'b1;
    tick;

    // Delay 3, three back-to-back items.
    dly = 4'd3; #1;
    chk("d3_chg_rdy", 32'(rdy), 0);
    tick;
    chk("d3_rdy", 32'(rdy), 1);
    vld = 1'b1; din = pk(8'h11); tick;
    chk("d3_busy", 32'(busy), 1);
    chk("d3_early0", 32'(ovld), 0);
    din = pk(8'h22); tick;
    chk("d3_early1", 32'(ovld), 0);
    din = pk(8'h33); tick;
    chk("d3_v11", 32'(ovld), 1);
    chk("d3_d11", 32'(dout), 32'(pk(8'h11)));
    vld = 1'b0; tick;
    chk("d3_v22", 32'(ovld), 1);
    chk("d3_d22", 32'(dout), 32'(pk(8'h22)));
    tick;
    chk("d3_v33", 32'(ovld), 1);
    chk("d3_d33", 32'(dout), 32'(pk(8'h33)));
    tick;
    chk("d3_end", 32'(ovld), 0);
    chk("d3_idle", 32'(busy), 0);

    // Delay 4 with stalls mid-stream.
    dly = 4'd4; #1;
    chk("d4_chg_rdy", 32'(rdy), 0);
    tick;
    chk("d4_rdy", 32'(rdy), 1);
    vld = 1'b1; din = pk(8'h44); tick;
    din = pk(8'h55); tick;
    vld = 1'b0; tick;
    chk("d4_pre", 32'(ovld), 0);
    en = 1'b0; tick; tick;
    chk("d4_stall", 32'(ovld), 0);
    en = 1'b1; tick;
    chk("d4_v44", 32'(ovld), 1);
    chk("d4_d44", 32'(dout), 32'(pk(8'h44)));
    en = 1'b0; tick;
    chk("d4_hold_v", 32'(ovld), 1);
    chk("d4_hold_d", 32'(dout), 32'(pk(8'h44)));
    en = 1'b1; tick;
    chk("d4_v55", 32'(ovld), 1);
    chk("d4_d55", 32'(dout), 32'(pk(8'h55)));
    tick;
    chk("d4_end", 32'(ovld), 0);
    chk("d4_idle", 32'(busy), 0);

    // Delay 0: combinational bypass, independent of i_en.
    dly = 4'd0; #1;
    chk("d0_chg_rdy", 32'(rdy), 0);
    tick;
    chk("d0_rdy", 32'(rdy), 1);
    vld = 1'b1; din = pk(8'h5A); en = 1'b0; #1;
    chk("d0_v_en0", 32'(ovld), 1);
    chk("d0_d_en0", 32'(dout), 32'(pk(8'h5A)));
    vld = 1'b0; #1;
    chk("d0_nv", 32'(ovld), 0);
    vld = 1'b1; din = pk(8'hC3); en = 1'b1; #1;
    chk("d0_d_en1", 32'(dout), 32'(pk(8'hC3)));
    tick;
    chk("d0_v_post", 32'(ovld), 1);
    chk("d0_busy", 32'(busy), 0);
    vld = 1'b0;

    // Delay 5 with three items, then request 2 while they are in flight.
    dly = 4'd5; #1;
    chk("d5_chg_rdy", 32'(rdy), 0);
    tick;
    chk("d5_rdy", 32'(rdy), 1);
    vld = 1'b1; din = pk(8'h61); tick;
    din = pk(8'h62); tick;
    din = pk(8'h63); tick;
    din = pk(8'hEE); dly = 4'd2; #1;
    chk("dr_rdy0", 32'(rdy), 0);
    tick;
    chk("dr_rdy1", 32'(rdy), 0);
    chk("dr_err", 32'(err), 0);
    tick;
    chk("dr_v61", 32'(ovld), 1);
    chk("dr_d61", 32'(dout), 32'(pk(8'h61)));
    tick;
    chk("dr_d62", 32'(dout), 32'(pk(8'h62)));
    tick;
    chk("dr_v63", 32'(ovld), 1);
    chk("dr_d63", 32'(dout), 32'(pk(8'h63)));
    chk("dr_rdy2", 32'(rdy), 0);
    tick;
    chk("dr_drained_v", 32'(ovld), 0);
    chk("dr_drained_b", 32'(busy), 0);
    chk("dr_rdy3", 32'(rdy), 0);
    tick;
    chk("dr_load_rdy", 32'(rdy), 1);
    chk("dr_load_v", 32'(ovld), 0);
    din = pk(8'h77); tick;
    vld = 1'b0;
    chk("d2_early", 32'(ovld), 0);
    tick;
    chk("d2_v77", 32'(ovld), 1);
    chk("d2_d77", 32'(dout), 32'(pk(8'h77)));
    chk("d2_err", 32'(err), 0);

    // Out-of-range request saturates to 8 and raises the error flag.
    dly = 4'd15; #1;
    chk("sat_chg_rdy", 32'(rdy), 0);
    tick;
    chk("sat_err1", 32'(err), 1);
    chk("sat_drain_rdy", 32'(rdy), 0);
    tick;
    chk("sat_rdy", 32'(rdy), 1);
    chk("sat_err2", 32'(err), 1);

    // Flush with four items in flight.
    vld = 1'b1;
    for (int i = 0; i < 4; i++) begin
      din = pk(8'h81 + 8'(i));
      tick;
    end
    chk("fl_busy", 32'(busy), 1);
    chk("fl_vld", 32'(ovld), 0);
`ifdef CM_DLY_PIPE_CNT_EN
    cnt_exp = 4;
`else
    cnt_exp = 0;
`endif
    chk("fl_cnt4", 32'(cnt), 32'(cnt_exp));
    flush = 1'b1; din = pk(8'h99); tick;
    flush = 1'b0; vld = 1'b0;
    chk("fl_v0", 32'(ovld), 0);
    chk("fl_busy0", 32'(busy), 0);
    chk("fl_cnt0", 32'(cnt), 0);
    repeat (8) tick;
    chk("fl_ghost", 32'(ovld), 0);

    // Saturated delay of 8 is in effect.
    vld = 1'b1; din = pk(8'hA5); tick;
    vld = 1'b0;
    repeat (6) tick;
    chk("d8_early", 32'(ovld), 0);
    tick;
    chk("d8_vA5", 32'(ovld), 1);
    chk("d8_dA5", 32'(dout), 32'(pk(8'hA5)));

    // Asynchronous reset between edges.
    #1 rst_n = 1'b0;
    #1;
    chk("arst_vld", 32'(ovld), 0);
    chk("arst_busy", 32'(busy), 0);
    chk("arst_err", 32'(err), 0);
    chk("arst_cnt", 32'(cnt), 0);
    chk("arst_rdy", 32'(rdy), 1);
    rst_n = 1'b1;
    tick;

    $display("CHECKS %0d ERRORS %0d", checks, errors);
    $finish;
  end

endmodule
